// File: rtl/dsp_ctrl_pkg.sv
// dsp_ctrl_pkg
//   Shared definitions for the DSP48A1-style MAC sequencer:
//   - controller state encoding
//   - OPMODE field encodings (X mux in bits [1:0], Z mux in bits [3:2])
//     and the two OPMODE words the sequencer issues
//   - depth of the slice's registered data path (A/B -> M -> P)
package dsp_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int OPM_W = 8;

    localparam logic [1:0] X_ZERO = 2'b00;
    localparam logic [1:0] X_M    = 2'b01;
    localparam logic [1:0] Z_ZERO = 2'b00;
    localparam logic [1:0] Z_P    = 2'b10;

    // P = M for the first product, P = P + M for every later one.
    localparam logic [OPM_W-1:0] OPM_FIRST = {4'b0000, Z_ZERO, X_M};
    localparam logic [OPM_W-1:0] OPM_ACC   = {4'b0000, Z_P, X_M};

    // AREG/BREG, MREG and PREG are all enabled.
    localparam int SLICE_DEPTH = 3;

endpackage

// File: rtl/dsp_mac_sequencer_if.sv
// dsp_mac_sequencer_if
//   Bundles the sequencer's command, sample, slice-control and result
//   signals.
//   slave  : the sequencer (takes start/len, in_valid, res_ready;
//            drives busy, in_ready, slice enables/reset/opmode, res_valid)
//   master : the surrounding logic / testbench
//
//   start, len          command strobe and term count
//   busy                sequencer not idle
//   in_valid, in_ready  A/B sample handshake
//   ce_ab, ce_m, ce_p   slice clock enables (CEA/CEB, CEM, CEP)
//   rst_p               slice RSTP (synchronous clear of P)
//   opmode              slice OPMODE
//   res_valid,res_ready result handshake
interface dsp_mac_sequencer_if #(
    parameter int LEN_W = 8
);
    logic                             start;
    logic [LEN_W-1:0]                 len;
    logic                             busy;
    logic                             in_valid;
    logic                             in_ready;
    logic                             ce_ab;
    logic                             ce_m;
    logic                             ce_p;
    logic                             rst_p;
    logic [dsp_ctrl_pkg::OPM_W-1:0]   opmode;
    logic                             res_valid;
    logic                             res_ready;

    modport slave (
        input  start, len, in_valid, res_ready,
        output busy, in_ready, ce_ab, ce_m, ce_p, rst_p, opmode, res_valid
    );

    modport master (
        output start, len, in_valid, res_ready,
        input  busy, in_ready, ce_ab, ce_m, ce_p, rst_p, opmode, res_valid
    );

endinterface

// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer
//   Sequences one DSP48A1-style slice (AREG=BREG=MREG=PREG=1,
//   OPMODEREG=0, sync reset on P) through an N-term multiply-accumulate
//   P = sum(A_i * B_i). A/B data go straight from the source to the
//   slice; this block only steers the enables, the P clear and OPMODE,
//   and presents the result while P is frozen.
//
//   clk   in   clock
//   rst   in   asynchronous, active-high reset
//   bus   slave modport of dsp_mac_sequencer_if (command, sample and
//         result handshakes, slice controls)
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | waiting for start; len captured into rem on start
//   CLEAR    | one cycle of rst_p to zero P, arms the first-product flag
//   RUN      | accepting samples; each accept decrements rem
//   DRAIN    | last sample taken, waiting for M and P stages to settle
//   DONE     | P holds the sum, res_valid high until res_ready
module dsp_mac_sequencer #(
    parameter int                             LEN_W     = 8,
    parameter logic [dsp_ctrl_pkg::OPM_W-1:0] OPM_FIRST = dsp_ctrl_pkg::OPM_FIRST,
    parameter logic [dsp_ctrl_pkg::OPM_W-1:0] OPM_ACC   = dsp_ctrl_pkg::OPM_ACC
) (
    input  logic                  clk,
    input  logic                  rst,
    dsp_mac_sequencer_if.slave    bus
);
    import dsp_ctrl_pkg::*;

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] rem;
    logic [LEN_W-1:0] rem_nxt;
    logic             first;
    logic             first_nxt;
    logic             v_m;
    logic             v_p;
    logic             in_ready_c;
    logic             fire;

    assign fire = in_ready_c & bus.in_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            rem   <= '0;
            first <= 1'b0;
            v_m   <= 1'b0;
            v_p   <= 1'b0;
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
            first <= first_nxt;
            // valid flags track a sample through the M and P registers
            v_m   <= fire;
            v_p   <= v_m;
        end
    end

    always_comb begin
        state_nxt  = state;
        rem_nxt    = rem;
        first_nxt  = first;
        in_ready_c = 1'b0;
        bus.rst_p     = 1'b0;
        bus.res_valid = 1'b0;

        // the first product has been written into P
        if (v_p) begin
            first_nxt = 1'b0;
        end

        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    rem_nxt   = bus.len;
                    state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                bus.rst_p = 1'b1;
                first_nxt = 1'b1;
                state_nxt = (rem != '0) ? ST_RUN : ST_DONE;
            end
            ST_RUN: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    rem_nxt = rem - LEN_W'(1);
                    if (rem == LEN_W'(1)) begin
                        state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // With v_m clear, v_p drops on this same edge, so the
                // final P load is the one happening now and DONE can be
                // entered next cycle with both flags at zero.
                if (!v_m) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                bus.res_valid = 1'b1;
                if (bus.res_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.busy     = (state != ST_IDLE);
    assign bus.in_ready = in_ready_c;
    assign bus.ce_ab    = fire;
    assign bus.ce_m     = v_m;
    assign bus.ce_p     = v_p;
    assign bus.opmode   = v_p ? (first ? OPM_FIRST : OPM_ACC) : '0;

endmodule
